// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter / input stage in front of the splitter.
// A master that loses the address phase is captured into a holding register,
// replayed on a later slot, and stalled until that replay's data phase ends.
// Optional feature: define AHBL_ARB_ROUND_ROBIN_EN for round-robin conflict
// resolution; otherwise M0 always wins conflicts.
module ahbl_master_arbiter #(
  parameter int PARK_MASTER = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);
  localparam logic PARK = (PARK_MASTER != 0);

  typedef enum logic [1:0] {DPH_NONE = 2'd0, DPH_M0 = 2'd1, DPH_M1 = 2'd2} dph_e;

  logic [1:0][31:0] m_haddr, m_hwdata;
  logic [1:0][1:0]  m_htrans;
  logic [1:0][2:0]  m_hsize;
  logic [1:0]       m_hwrite, m_hready, live, req, cap, dph_is;

  logic [1:0][31:0] pend_addr;
  logic [1:0][2:0]  pend_size;
  logic [1:0]       pend_write, pend_vld;

  logic gnt_q, gnt, gnt_pend, gnt_act, dph_rep;
  dph_e dph_own;
`ifdef AHBL_ARB_ROUND_ROBIN_EN
  logic last_gnt;
`endif

  assign m_haddr  = {M1_HADDR, M0_HADDR};
  assign m_hwdata = {M1_HWDATA, M0_HWDATA};
  assign m_htrans = {M1_HTRANS, M0_HTRANS};
  assign m_hsize  = {M1_HSIZE, M0_HSIZE};
  assign m_hwrite = {M1_HWRITE, M0_HWRITE};
  assign dph_is   = {dph_own == DPH_M1, dph_own == DPH_M0};

  // Live NONSEQ/SEQ is a request; a pending capture always requests too.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      live[i] = m_htrans[i] inside {2'b10, 2'b11};
      req[i]  = pend_vld[i] | live[i];
    end
  end

  // Grant: frozen during wait states, otherwise single requester or conflict rule.
  always_comb begin
    gnt = gnt_q;
    if (HREADY) begin
      unique case (req)
        2'b01:   gnt = 1'b0;
        2'b10:   gnt = 1'b1;
`ifdef AHBL_ARB_ROUND_ROBIN_EN
        2'b11:   gnt = ~last_gnt;
`else
        2'b11:   gnt = 1'b0;
`endif
        default: gnt = PARK;
      endcase
    end
    gnt_pend = pend_vld[gnt];
    gnt_act  = gnt_pend | live[gnt];
  end

  // Per-master ready and capture decision.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (pend_vld[i])                   m_hready[i] = dph_is[i] & dph_rep & HREADY;
      else if (dph_is[i])                m_hready[i] = HREADY;
      else if (gnt == i[0] && live[i])   m_hready[i] = HREADY;
      else                               m_hready[i] = 1'b1;
      cap[i] = live[i] & m_hready[i] & ~((gnt == i[0]) & HREADY & ~pend_vld[i]);
    end
  end

  // Holding registers: set on capture, cleared when the replay is granted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_vld   <= '0;
      pend_addr  <= '0;
      pend_write <= '0;
      pend_size  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cap[i]) begin
          pend_vld[i]   <= 1'b1;
          pend_addr[i]  <= m_haddr[i];
          pend_write[i] <= m_hwrite[i];
          pend_size[i]  <= m_hsize[i];
        end else if (HREADY && gnt == i[0] && pend_vld[i]) begin
          pend_vld[i]   <= 1'b0;
        end
      end
    end
  end

  // Address-owner and data-phase tracking, advanced only when the slave is ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_q   <= PARK;
      dph_own <= DPH_NONE;
      dph_rep <= 1'b0;
`ifdef AHBL_ARB_ROUND_ROBIN_EN
      last_gnt <= 1'b1;
`endif
    end else if (HREADY) begin
      gnt_q   <= gnt;
      dph_own <= gnt_act ? (gnt ? DPH_M1 : DPH_M0) : DPH_NONE;
      dph_rep <= gnt_act & gnt_pend;
`ifdef AHBL_ARB_ROUND_ROBIN_EN
      if (gnt_act) last_gnt <= gnt;
`endif
    end
  end

  // Address phase from the pending copy or the live master; SEQ becomes NONSEQ.
  always_comb begin
    HTRANS = gnt_act ? 2'b10 : 2'b00;
    HADDR  = gnt_pend ? pend_addr[gnt]  : m_haddr[gnt];
    HWRITE = gnt_pend ? pend_write[gnt] : m_hwrite[gnt];
    HSIZE  = gnt_pend ? pend_size[gnt]  : m_hsize[gnt];
  end

  // Write data follows the data-phase owner; park master when idle.
  always_comb begin
    unique case (dph_own)
      DPH_M0:  HWDATA = M0_HWDATA;
      DPH_M1:  HWDATA = M1_HWDATA;
      default: HWDATA = m_hwdata[PARK];
    endcase
  end

  assign M0_HREADY = m_hready[0];
  assign M1_HREADY = m_hready[1];
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;
endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed bench for ahbl_master_arbiter (PARK_MASTER = 0).
module tb_ahbl_master_arbiter;
  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS, HTRANS;
  logic        M0_HWRITE, M1_HWRITE, M0_HREADY, M1_HREADY, HWRITE, HREADY;
  logic [2:0]  M0_HSIZE, M1_HSIZE, HSIZE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  int pass_cnt = 0, total_cnt = 0;

  ahbl_master_arbiter #(.PARK_MASTER(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic nxt();
    @(posedge HCLK); #1;
  endtask

  task automatic idle_all();
    M0_HTRANS = 2'b00; M1_HTRANS = 2'b00; HREADY = 1'b1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    M0_HADDR = 32'hA0; M1_HADDR = 32'hB0; M0_HWDATA = 32'hD0; M1_HWDATA = 32'hD1;
    M0_HWRITE = 1'b0; M1_HWRITE = 1'b0; M0_HSIZE = 3'd2; M1_HSIZE = 3'd2;
    HRDATA = 32'h0; idle_all();
    nxt(); nxt();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    M0_HADDR = 32'hA0; M1_HADDR = 32'hB0; M0_HWDATA = 32'hD0; M1_HWDATA = 32'hD1;
    M0_HWRITE = 1'b0; M1_HWRITE = 1'b0; M0_HSIZE = 3'd2; M1_HSIZE = 3'd2;
    HRDATA = 32'h0; idle_all();
    nxt(); #4;
    total_cnt++; if (HTRANS !== 2'b00) $display("FAIL rst_htrans got %h exp 0", HTRANS); else pass_cnt++;
    total_cnt++; if (M0_HREADY !== 1'b1) $display("FAIL rst_m0rdy got %b exp 1", M0_HREADY); else pass_cnt++;
    total_cnt++; if (M1_HREADY !== 1'b1) $display("FAIL rst_m1rdy got %b exp 1", M1_HREADY); else pass_cnt++;
    total_cnt++; if (HADDR !== 32'hA0) $display("FAIL rst_haddr got %h exp a0", HADDR); else pass_cnt++;
    total_cnt++; if (HWDATA !== 32'hD0) $display("FAIL rst_hwdata got %h exp d0", HWDATA); else pass_cnt++;
    nxt(); HRESETn = 1'b1;
  endtask

  task automatic test_single_read();
    nxt();
    M0_HADDR = 32'h2000_0010; M0_HTRANS = 2'b10; M0_HWRITE = 1'b0; #4;
    total_cnt++; if (HTRANS !== 2'b10) $display("FAIL rd_htrans got %h exp 2", HTRANS); else pass_cnt++;
    total_cnt++; if (HADDR !== 32'h2000_0010) $display("FAIL rd_haddr got %h exp 20000010", HADDR); else pass_cnt++;
    total_cnt++; if (M0_HREADY !== 1'b1) $display("FAIL rd_m0rdy got %b exp 1", M0_HREADY); else pass_cnt++;
    nxt();
    M0_HTRANS = 2'b00; HRDATA = 32'h1234_5678; #4;
    total_cnt++; if (M0_HRDATA !== 32'h1234_5678) $display("FAIL rd_hrdata got %h exp 12345678", M0_HRDATA); else pass_cnt++;
    total_cnt++; if (M1_HREADY !== 1'b1) $display("FAIL rd_m1rdy got %b exp 1", M1_HREADY); else pass_cnt++;
    total_cnt++; if (HTRANS !== 2'b00) $display("FAIL rd_idle got %h exp 0", HTRANS); else pass_cnt++;
  endtask

  task automatic test_conflict();
    do_reset(); nxt();
    M0_HADDR = 32'h100; M0_HWRITE = 1'b1; M0_HTRANS = 2'b10;
    M1_HADDR = 32'h200; M1_HWRITE = 1'b1; M1_HTRANS = 2'b11; #4;
    total_cnt++; if (HADDR !== 32'h100) $display("FAIL cf_a_haddr got %h exp 100", HADDR); else pass_cnt++;
    total_cnt++; if (HTRANS !== 2'b10) $display("FAIL cf_a_htrans got %h exp 2", HTRANS); else pass_cnt++;
    nxt();
    idle_all(); M1_HADDR = 32'hBAD; M0_HWDATA = 32'hAAAA; M1_HWDATA = 32'hBBBB; #4;
    total_cnt++; if (HADDR !== 32'h200) $display("FAIL cf_b_haddr got %h exp 200", HADDR); else pass_cnt++;
    total_cnt++; if (HTRANS !== 2'b10) $display("FAIL cf_b_htrans got %h exp 2", HTRANS); else pass_cnt++;
    total_cnt++; if (HWDATA !== 32'hAAAA) $display("FAIL cf_b_hwdata got %h exp aaaa", HWDATA); else pass_cnt++;
    total_cnt++; if (M1_HREADY !== 1'b0) $display("FAIL cf_b_m1rdy got %b exp 0", M1_HREADY); else pass_cnt++;
    nxt(); #4;
    total_cnt++; if (HWDATA !== 32'hBBBB) $display("FAIL cf_c_hwdata got %h exp bbbb", HWDATA); else pass_cnt++;
    total_cnt++; if (M1_HREADY !== 1'b1) $display("FAIL cf_c_m1rdy got %b exp 1", M1_HREADY); else pass_cnt++;
    total_cnt++; if (HTRANS !== 2'b00) $display("FAIL cf_c_htrans got %h exp 0", HTRANS); else pass_cnt++;
  endtask

  task automatic test_starve();
    do_reset(); nxt();
    M0_HADDR = 32'h100; M0_HTRANS = 2'b10; M1_HADDR = 32'h500; M1_HWRITE = 1'b1; M1_HTRANS = 2'b10;
    nxt();
    M1_HTRANS = 2'b00; M1_HWDATA = 32'h5555;
`ifdef AHBL_ARB_ROUND_ROBIN_EN
    M0_HADDR = 32'h104; #4;
    total_cnt++; if (HADDR !== 32'h500) $display("FAIL rr_haddr got %h exp 500", HADDR); else pass_cnt++;
    nxt(); idle_all();
`else
    for (int k = 0; k < 4; k++) begin
      M0_HADDR = 32'h104 + 32'(4 * k); #4;
      total_cnt++; if (HADDR !== 32'h104 + 32'(4 * k)) $display("FAIL st_haddr%0d got %h exp %h", k, HADDR, 32'h104 + 32'(4 * k)); else pass_cnt++;
      total_cnt++; if (M1_HREADY !== 1'b0) $display("FAIL st_m1rdy%0d got %b exp 0", k, M1_HREADY); else pass_cnt++;
      nxt();
    end
    M0_HTRANS = 2'b00; #4;
    total_cnt++; if (HADDR !== 32'h500) $display("FAIL st_rep_haddr got %h exp 500", HADDR); else pass_cnt++;
    total_cnt++; if (M1_HREADY !== 1'b0) $display("FAIL st_rep_m1rdy got %b exp 0", M1_HREADY); else pass_cnt++;
    nxt(); #4;
    total_cnt++; if (HWDATA !== 32'h5555) $display("FAIL st_hwdata got %h exp 5555", HWDATA); else pass_cnt++;
    total_cnt++; if (M1_HREADY !== 1'b1) $display("FAIL st_done_m1rdy got %b exp 1", M1_HREADY); else pass_cnt++;
`endif
  endtask

  task automatic test_wait_states();
    do_reset(); nxt();
    M0_HADDR = 32'h300; M0_HWRITE = 1'b1; M0_HTRANS = 2'b10;
    M1_HADDR = 32'h400; M1_HWRITE = 1'b1; M1_HTRANS = 2'b10;
    nxt();
    idle_all(); M0_HWDATA = 32'h1111; M1_HWDATA = 32'h2222; #4;
    total_cnt++; if (HADDR !== 32'h400) $display("FAIL ws_rep_haddr got %h exp 400", HADDR); else pass_cnt++;
    nxt();
    HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      total_cnt++; if (HWDATA !== 32'h2222) $display("FAIL ws_hwdata%0d got %h exp 2222", k, HWDATA); else pass_cnt++;
      total_cnt++; if (HADDR !== 32'h400) $display("FAIL ws_haddr%0d got %h exp 400", k, HADDR); else pass_cnt++;
      total_cnt++; if (M1_HREADY !== 1'b0) $display("FAIL ws_m1rdy%0d got %b exp 0", k, M1_HREADY); else pass_cnt++;
      total_cnt++; if (M0_HREADY !== 1'b1) $display("FAIL ws_m0rdy%0d got %b exp 1", k, M0_HREADY); else pass_cnt++;
      nxt();
    end
    HREADY = 1'b1; #4;
    total_cnt++; if (M1_HREADY !== 1'b1) $display("FAIL ws_end_m1rdy got %b exp 1", M1_HREADY); else pass_cnt++;
    total_cnt++; if (HWDATA !== 32'h2222) $display("FAIL ws_end_hwdata got %h exp 2222", HWDATA); else pass_cnt++;
    nxt(); #4;
    total_cnt++; if (HWDATA !== 32'h1111) $display("FAIL ws_post_hwdata got %h exp 1111", HWDATA); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset(); nxt();
    M0_HADDR = 32'h600; M0_HTRANS = 2'b10; M1_HADDR = 32'h700; M1_HTRANS = 2'b10;
    M0_HWDATA = 32'hC0; M1_HWDATA = 32'hC1;
    nxt();
    idle_all(); #1;
    total_cnt++; if (HTRANS !== 2'b10) $display("FAIL rm_pre_htrans got %h exp 2", HTRANS); else pass_cnt++;
    HRESETn = 1'b0; #1;
    total_cnt++; if (HTRANS !== 2'b00) $display("FAIL rm_htrans got %h exp 0", HTRANS); else pass_cnt++;
    total_cnt++; if (M1_HREADY !== 1'b1) $display("FAIL rm_m1rdy got %b exp 1", M1_HREADY); else pass_cnt++;
    total_cnt++; if (HWDATA !== 32'hC0) $display("FAIL rm_hwdata got %h exp c0", HWDATA); else pass_cnt++;
    nxt(); HRESETn = 1'b1;
    nxt(); #4;
    total_cnt++; if (HTRANS !== 2'b00) $display("FAIL rm_post_htrans got %h exp 0", HTRANS); else pass_cnt++;
    total_cnt++; if (M1_HREADY !== 1'b1) $display("FAIL rm_post_m1rdy got %b exp 1", M1_HREADY); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_conflict();
    test_starve();
    test_wait_states();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
